// File: rtl/code_sram_arb.sv
// Two-port round-robin arbiter in front of the single-port code SRAM.
// Port 0 is instruction fetch and port 1 is debug/constant read. The block
// issues at most one read per cycle. It routes each 1-cycle-latency result
// back to its requester and parks it in a per-port buffer until accepted.
module code_sram_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req_valid,
  input  logic [ADDR_WIDTH-1:0] m0_req_addr,
  output logic                  m0_req_ready,
  output logic                  m0_rsp_valid,
  output logic [DATA_WIDTH-1:0] m0_rsp_data,
  input  logic                  m0_rsp_ready,
  input  logic                  m1_req_valid,
  input  logic [ADDR_WIDTH-1:0] m1_req_addr,
  output logic                  m1_req_ready,
  output logic                  m1_rsp_valid,
  output logic [DATA_WIDTH-1:0] m1_rsp_data,
  input  logic                  m1_rsp_ready,
  output logic                  sram_en,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  logic [1:0] req_valid, rsp_ready, rsp_valid, pending, eligible, grant;
  logic [1:0] inflight_q, inflight_d;
  logic [1:0] held_q, held_d;
  logic [DATA_WIDTH-1:0] hold_data_q [2];
  logic [DATA_WIDTH-1:0] hold_data_d [2];
  // 1 means port 1 was granted last, so port 0 wins the next tie.
  logic last_grant_q, last_grant_d;

  assign req_valid = {m1_req_valid, m0_req_valid};
  assign rsp_ready = {m1_rsp_ready, m0_rsp_ready};
  assign pending   = inflight_q | held_q;
  assign rsp_valid = inflight_q | held_q;
  // A port may issue again in the same cycle its outstanding response is accepted.
  assign eligible  = req_valid & (~pending | (rsp_valid & rsp_ready));

  // Round-robin choice between eligible ports; gated by reset so nothing issues during reset.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    grant        = 2'b00;
    last_grant_d = last_grant_q;
    if (rst_n) begin
      if (eligible == 2'b11) grant = last_grant_q ? 2'b01 : 2'b10;
      else                   grant = eligible;
    end
    if (grant != 2'b00) last_grant_d = grant[1];
  end

  assign m0_req_ready = grant[0];
  assign m1_req_ready = grant[1];
  assign sram_en      = |grant;
  assign sram_addr    = grant[0] ? m0_req_addr :
                        grant[1] ? m1_req_addr : '0;

  assign m0_rsp_valid = rsp_valid[0];
  assign m1_rsp_valid = rsp_valid[1];
  // Held data wins. Otherwise pass the SRAM output through only while a read is in flight.
  assign m0_rsp_data  = held_q[0]     ? hold_data_q[0] :
                        inflight_q[0] ? sram_dout      : '0;
  assign m1_rsp_data  = held_q[1]     ? hold_data_q[1] :
                        inflight_q[1] ? sram_dout      : '0;

  // Next-state for the in-flight and held flags and the hold buffers.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      inflight_d[i]  = grant[i];
      held_d[i]      = held_q[i];
      hold_data_d[i] = hold_data_q[i];
      // An unaccepted in-flight result must be captured now, since sram_dout is only valid this cycle.
      if (inflight_q[i] && !rsp_ready[i]) begin
        held_d[i]      = 1'b1;
        hold_data_d[i] = sram_dout;
      end
      if (held_q[i] && rsp_ready[i]) held_d[i] = 1'b0;
    end
  end

  // State registers; reset discards any read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q     <= '0;
      held_q         <= '0;
      last_grant_q   <= 1'b1;
      // NOTE: the hold buffers are reset too, so rsp_data reads 0 out of reset.
      hold_data_q[0] <= '0;
      hold_data_q[1] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      inflight_q     <= inflight_d;
      held_q         <= held_d;
      last_grant_q   <= last_grant_d;
      hold_data_q[0] <= hold_data_d[0];
      hold_data_q[1] <= hold_data_d[1];
    end
  end

endmodule

// File: tb/tb_code_sram_arb.sv
// Self-checking bench for code_sram_arb. A behavioural 1-cycle SRAM feeds the DUT.
// Each grant pushes the expected word onto that port's queue. The negedge
// monitor compares every valid response against the queue head and pops it on accept.
module tb_code_sram_arb;
  localparam int DW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req_valid, m0_req_ready, m0_rsp_valid, m0_rsp_ready;
  logic          m1_req_valid, m1_req_ready, m1_rsp_valid, m1_rsp_ready;
  logic [AW-1:0] m0_req_addr, m1_req_addr, sram_addr;
  logic [DW-1:0] m0_rsp_data, m1_rsp_data, sram_dout;
  logic          sram_en;

  int checks   = 0;
  int failures = 0;
  int acc0     = 0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  always #5 clk = ~clk;

  code_sram_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_valid(m0_req_valid), .m0_req_addr(m0_req_addr), .m0_req_ready(m0_req_ready),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_data(m0_rsp_data), .m0_rsp_ready(m0_rsp_ready),
    .m1_req_valid(m1_req_valid), .m1_req_addr(m1_req_addr), .m1_req_ready(m1_req_ready),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_data(m1_rsp_data), .m1_rsp_ready(m1_rsp_ready),
    .sram_en(sram_en), .sram_addr(sram_addr), .sram_dout(sram_dout)
  );

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return {8'hC0, a, ~a, a ^ 8'h5A};
  endfunction

  // Registered-read SRAM model.
  always @(posedge clk) if (sram_en) sram_dout <= mem_val(sram_addr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("dual_grant", {m0_req_ready, m1_req_ready} == 2'b11, 1'b0);
      check("sram_en", sram_en, m0_req_ready | m1_req_ready);
      if (m0_req_ready) check("sram_addr_m0", sram_addr, m0_req_addr);
      if (m1_req_ready) check("sram_addr_m1", sram_addr, m1_req_addr);
      check("m0_rsp_valid", m0_rsp_valid, q0.size() > 0);
      check("m1_rsp_valid", m1_rsp_valid, q1.size() > 0);
      if (m0_rsp_valid && q0.size() > 0) begin
        check("m0_rsp_data", m0_rsp_data, q0[0]);
        if (m0_rsp_ready) begin
          void'(q0.pop_front());
          acc0++;
        end
      end
      if (m1_rsp_valid && q1.size() > 0) begin
        check("m1_rsp_data", m1_rsp_data, q1[0]);
        if (m1_rsp_ready) void'(q1.pop_front());
      end
      if (m0_req_ready) q0.push_back(mem_val(m0_req_addr));
      if (m1_req_ready) q1.push_back(mem_val(m1_req_addr));
    end
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  idx;
    int  acc_start;
    bit  seen;
    logic tgl;
    rst_n = 1'b0;
    m0_req_valid = 1'b1; m0_req_addr = 8'h00; m0_rsp_ready = 1'b0;
    m1_req_valid = 1'b1; m1_req_addr = 8'h00; m1_rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state: grant logic gated even with requests pending.
    check("rst_m0_req_ready", m0_req_ready, 1'b0);
    check("rst_m1_req_ready", m1_req_ready, 1'b0);
    check("rst_sram_en", sram_en, 1'b0);
    check("rst_m0_rsp_valid", m0_rsp_valid, 1'b0);
    check("rst_m1_rsp_data", m1_rsp_data, 32'h0);
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    // Single read of 0x05 on port 0.
    drive_edge();
    m0_req_valid = 1'b1; m0_req_addr = 8'h05; m0_rsp_ready = 1'b1;
    @(negedge clk);
    check("t1_grant", m0_req_ready, 1'b1);
    check("t1_sram_en", sram_en, 1'b1);
    check("t1_sram_addr", sram_addr, 8'h05);
    drive_edge();
    m0_req_valid = 1'b0;
    @(negedge clk);
    check("t1_rsp_valid", m0_rsp_valid, 1'b1);
    check("t1_rsp_data", m0_rsp_data, mem_val(8'h05));

    // Both ports request every cycle; port 0 went last, so port 1 leads.
    drive_edge();
    m0_req_valid = 1'b1; m0_req_addr = 8'h10;
    m1_req_valid = 1'b1; m1_req_addr = 8'h20; m1_rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rr_m1_grant", m1_req_ready, (i % 2) == 0);
      check("rr_m0_grant", m0_req_ready, (i % 2) == 1);
      drive_edge();
    end

    // Backpressure on port 1 after one of its reads.
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      @(negedge clk);
      if (m1_req_ready) seen = 1'b1;
    end
    check("bp_m1_grant_seen", seen, 1'b1);
    drive_edge();
    m1_rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_m1_valid", m1_rsp_valid, 1'b1);
      check("bp_m1_data", m1_rsp_data, mem_val(8'h20));
      check("bp_m1_no_grant", m1_req_ready, 1'b0);
      check("bp_m0_grant", m0_req_ready, 1'b1);
      drive_edge();
    end
    m1_rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_m1_regrant", m1_req_ready, 1'b1);
    drive_edge();
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    repeat (3) drive_edge();

    // Port 0 streams 0x00..0x07 while its rsp_ready toggles.
    idx = 0; tgl = 1'b1; acc_start = acc0;
    for (int c = 0; c < 40; c++) begin
      m0_rsp_ready = tgl;
      tgl          = ~tgl;
      m0_req_valid = (idx < 8);
      m0_req_addr  = AW'(idx);
      @(negedge clk);
      if (m0_req_ready) idx++;
      drive_edge();
    end
    m0_req_valid = 1'b0; m0_rsp_ready = 1'b1;
    repeat (3) drive_edge();
    check("stream_issued", idx, 8);
    check("stream_accepted", acc0 - acc_start, 8);

    // Reset while a read is in flight.
    m0_req_valid = 1'b1; m0_req_addr = 8'h03; m0_rsp_ready = 1'b0;
    @(negedge clk);
    check("rst_mid_grant", m0_req_ready, 1'b1);
    drive_edge();
    m0_req_valid = 1'b0; m1_req_valid = 1'b1; m1_req_addr = 8'h44;
    rst_n = 1'b0;
    q0.delete(); q1.delete();
    #1;
    check("rst_mid_m0_valid", m0_rsp_valid, 1'b0);
    check("rst_mid_m1_ready", m1_req_ready, 1'b0);
    check("rst_mid_sram_en", sram_en, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; m1_req_valid = 1'b0; m0_rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_no_stale", m0_rsp_valid, 1'b0);
    end

    // Idle window.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("idle_sram_en", sram_en, 1'b0);
      check("idle_sram_addr", sram_addr, 8'h00);
    end
    check("drain_q0", q0.size(), 0);
    check("drain_q1", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
